// File: rtl/connect4_pkg.sv
// connect4_pkg
// Shared constants, types and helpers for the disc-drop game grid.
//   ROWS, COLS      : grid geometry (row 0 = bottom)
//   drop_state_t    : drop controller states
//   player_t        : whose turn it is
//   onehot_to_index : column_select decode to index plus one-hot valid flag
package connect4_pkg;

  localparam int ROWS  = 6;
  localparam int COLS  = 7;
  localparam int COL_W = $clog2(COLS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FALL = 2'd1,
    LAND = 2'd2
  } drop_state_t;

  typedef enum logic {
    PLAYER_RED   = 1'b0,
    PLAYER_GREEN = 1'b1
  } player_t;

  typedef struct packed {
    logic             valid;
    logic [COL_W-1:0] index;
  } col_sel_t;

  // valid is set only when exactly one bit of sel is high.
  function automatic col_sel_t onehot_to_index(input logic [COLS-1:0] sel);
    col_sel_t    r;
    int unsigned ones;
    r    = '0;
    ones = 0;
    for (int i = 0; i < COLS; i++) begin
      if (sel[i]) begin
        ones    = ones + 1;
        r.index = COL_W'(i);
      end
    end
    r.valid = (ones == 1);
    return r;
  endfunction

endpackage

// File: rtl/drop_fall_timer.sv
// drop_fall_timer
// Per-row dwell timer for the falling disc. Counts 0..FALL_TICKS-1 while
// enable is high and pulses tick on the terminal count, then wraps.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   clear  : synchronous restart of the count (wins over enable)
//   enable : count this cycle
//   tick   : terminal-count pulse (combinational from count and enable)
module drop_fall_timer #(
  parameter int FALL_TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(FALL_TICKS - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/disc_drop_grid.sv
// disc_drop_grid
// Game grid: takes one-hot column drop requests, animates the disc falling
// one row per FALL_TICKS cycles, commits it for the current player and
// toggles the turn.
//   clk, reset          : clock, asynchronous active-low reset
//   column_select       : one-hot drop request pulse (all-zero = none)
//   lock                : game over, requests ignored silently
//   red_board/green_board : disc bitmaps, bit r*COLS+c
//   turn                : 0 = red to move, 1 = green
//   busy                : a drop is in progress (state != IDLE)
//   falling_valid/row/col : falling disc position during FALL
//   drop_done           : one-cycle pulse in LAND
//   invalid             : one-cycle pulse after a rejected request
//   board_full          : every cell is occupied
//   state_dbg           : current controller state (drop_state_t encoding)
//
// Request handshake: column_select is a fire-and-forget pulse with no ready.
// It is evaluated only while busy == 0 and lock == 0; at any other time it is
// dropped without a response. An evaluated request answers with exactly one
// of: a completed drop (busy high, ending in drop_done) or an invalid pulse.
module disc_drop_grid #(
  parameter int ROWS       = connect4_pkg::ROWS,
  parameter int COLS       = connect4_pkg::COLS,
  parameter int FALL_TICKS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [COLS-1:0]          column_select,
  input  logic                     lock,
  output logic [ROWS*COLS-1:0]     red_board,
  output logic [ROWS*COLS-1:0]     green_board,
  output logic                     turn,
  output logic                     busy,
  output logic                     falling_valid,
  output logic [$clog2(ROWS)-1:0]  falling_row,
  output logic [$clog2(COLS)-1:0]  falling_col,
  output logic                     drop_done,
  output logic                     invalid,
  output logic                     board_full,
  output logic [1:0]               state_dbg
);

  import connect4_pkg::*;

  localparam int CELLS = ROWS * COLS;
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int HW    = $clog2(ROWS + 1);
  localparam int NW    = $clog2(CELLS + 1);
  localparam int BW    = $clog2(CELLS);

  drop_state_t   state;
  player_t       turn_q;
  logic [HW-1:0] height [COLS];
  logic [NW-1:0] disc_count;
  logic [RW-1:0] target;

  col_sel_t         req;
  logic             req_present;
  logic             req_bad;
  logic             accept;
  logic [HW-1:0]    req_height;
  logic [BW-1:0]    land_idx;
  logic [CELLS-1:0] land_mask;
  logic             tick;

  always_comb begin
    req         = onehot_to_index(column_select);
    req_present = |column_select;
    req_height  = height[req.index];
    req_bad     = !req.valid || board_full || (req_height == HW'(ROWS));
    accept      = (state == IDLE) && req_present && !lock && !req_bad;
    land_idx    = BW'(target) * BW'(COLS) + BW'(falling_col);
    land_mask   = CELLS'(1) << land_idx;
  end

  // Restarted on accept so the first row gets its full dwell time.
  drop_fall_timer #(
    .FALL_TICKS (FALL_TICKS)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (state == FALL),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      turn_q        <= PLAYER_RED;
      red_board     <= '0;
      green_board   <= '0;
      for (int c = 0; c < COLS; c++) height[c] <= '0;
      disc_count    <= '0;
      target        <= '0;
      busy          <= 1'b0;
      falling_valid <= 1'b0;
      falling_row   <= '0;
      falling_col   <= '0;
      drop_done     <= 1'b0;
      invalid       <= 1'b0;
      board_full    <= 1'b0;
    end else begin
      drop_done <= 1'b0;
      invalid   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_present && !lock) begin
            if (req_bad) begin
              invalid <= 1'b1;
            end else begin
              falling_col   <= CW'(req.index);
              target        <= RW'(req_height);
              falling_row   <= RW'(ROWS - 1);
              falling_valid <= 1'b1;
              busy          <= 1'b1;
              state         <= FALL;
            end
          end
        end
        FALL: begin
          if (tick) begin
            if (falling_row == target) begin
              falling_valid <= 1'b0;
              drop_done     <= 1'b1;
              state         <= LAND;
            end else begin
              falling_row <= falling_row - RW'(1);
            end
          end
        end
        LAND: begin
          if (turn_q == PLAYER_RED) red_board   <= red_board | land_mask;
          else                      green_board <= green_board | land_mask;
          if (height[falling_col] != HW'(ROWS))
            height[falling_col] <= height[falling_col] + HW'(1);
          disc_count <= disc_count + NW'(1);
          board_full <= ((disc_count + NW'(1)) == NW'(CELLS));
          turn_q     <= (turn_q == PLAYER_RED) ? PLAYER_GREEN : PLAYER_RED;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign turn      = turn_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_disc_drop_grid.sv
// tb_disc_drop_grid
// Directed bench for disc_drop_grid with an event scoreboard: drivers push
// the expected board snapshot for each evaluated request; the monitor pops
// on every invalid pulse or completed drop and compares.
module tb_disc_drop_grid;

  localparam int ROWS  = 6;
  localparam int COLS  = 7;
  localparam int FT    = 4;
  localparam int CELLS = ROWS * COLS;
  localparam int W     = 1 + CELLS + CELLS + 1 + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [COLS-1:0]  column_select;
  logic             lock;
  logic [CELLS-1:0] red_board, green_board;
  logic             turn, busy, falling_valid, drop_done, invalid, board_full;
  logic [2:0]       falling_row, falling_col;
  logic [1:0]       state_dbg;

  int tests = 0;
  int fails = 0;

  logic [W-1:0]     exp_q[$];
  logic [CELLS-1:0] m_red, m_green;
  logic             m_turn;
  int               m_h [COLS];
  int               m_count;

  // clock / reset block
  always #5 clk = ~clk;

  disc_drop_grid #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .FALL_TICKS (FT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .column_select (column_select),
    .lock          (lock),
    .red_board     (red_board),
    .green_board   (green_board),
    .turn          (turn),
    .busy          (busy),
    .falling_valid (falling_valid),
    .falling_row   (falling_row),
    .falling_col   (falling_col),
    .drop_done     (drop_done),
    .invalid       (invalid),
    .board_full    (board_full),
    .state_dbg     (state_dbg)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_red"},    red_board, 0);
    check({tag, "_green"},  green_board, 0);
    check({tag, "_turn"},   turn, 0);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_fvalid"}, falling_valid, 0);
    check({tag, "_frow"},   falling_row, 0);
    check({tag, "_fcol"},   falling_col, 0);
    check({tag, "_done"},   drop_done, 0);
    check({tag, "_inv"},    invalid, 0);
    check({tag, "_full"},   board_full, 0);
    check({tag, "_state"},  state_dbg, 0);
  endtask

  task automatic model_clear();
    m_red = '0; m_green = '0; m_turn = 1'b0; m_count = 0;
    for (int c = 0; c < COLS; c++) m_h[c] = 0;
  endtask

  task automatic push_exp(input logic kind);
    exp_q.push_back({kind, m_red, m_green, m_turn, (m_count == CELLS)});
  endtask

  // Drivers: all called and returning at posedge + 1.
  task automatic pulse(input logic [COLS-1:0] v);
    column_select = v;
    @(posedge clk); #1;
    column_select = '0;
  endtask

  task automatic drop_ok(input int col, input logic check_rows, input logic [COLS-1:0] intrude);
    int t, n, exp_busy;
    logic [COLS-1:0] v;
    t = m_h[col];
    v = COLS'(1) << col;
    if (m_turn == 1'b0) m_red[t*COLS+col] = 1'b1;
    else                m_green[t*COLS+col] = 1'b1;
    m_h[col]++;
    m_count++;
    m_turn = ~m_turn;
    push_exp(1'b0);
    pulse(v);
    n = 0;
    exp_busy = (ROWS - t) * FT + 1;
    while (busy && n < 400) begin
      if (check_rows) begin
        if (n < exp_busy - 1) begin
          check("falling_row", falling_row, 64'(ROWS - 1 - n / FT));
          check("falling_valid", falling_valid, 1);
          check("falling_col", falling_col, 64'(col));
        end else begin
          check("drop_done_land", drop_done, 1);
        end
      end
      column_select = (n == 5) ? intrude : '0;
      n++;
      @(posedge clk); #1;
    end
    column_select = '0;
    check("busy_cycles", 64'(n), 64'(exp_busy));
  endtask

  task automatic drop_bad(input logic [COLS-1:0] v);
    push_exp(1'b1);
    pulse(v);
    @(posedge clk); #1;
  endtask

  task automatic drop_ignored(input logic [COLS-1:0] v);
    pulse(v);
    check("ignored_busy", busy, 0);
    @(posedge clk); #1;
    check("ignored_red", red_board, 64'(m_red));
    check("ignored_green", green_board, 64'(m_green));
    check("ignored_turn", turn, 64'(m_turn));
  endtask

  // Scoreboard monitor
  initial begin : monitor
    logic [W-1:0] act, e;
    forever begin
      @(negedge clk);
      if (invalid || drop_done) begin
        if (drop_done) begin
          @(negedge clk);
          act = {1'b0, red_board, green_board, turn, board_full};
        end else begin
          act = {1'b1, red_board, green_board, turn, board_full};
        end
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event: got %h expected no event", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            fails++;
            $display("FAIL event: got %h expected %h", act, e);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    column_select = '0;
    lock = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // First drop into column 3 with full falling-row trace
    drop_ok(3, 1'b1, '0);
    check("t1_red", red_board, 64'h8);
    check("t1_turn", turn, 1);

    // Fill column 0, alternating players starting with green
    for (int i = 0; i < ROWS; i++) drop_ok(0, 1'b0, '0);
    check("t2_red", red_board, 64'h8_0020_0088);
    check("t2_green", green_board, 64'h0_1000_4001);
    check("t2_turn", turn, 1);
    drop_bad(7'b0000001);
    check("t2_turn_after_invalid", turn, 1);

    // Non-one-hot request, then a request during FALL
    drop_bad(7'b0000011);
    drop_ok(1, 1'b0, 7'b0010000);
    check("t3_col4_empty", red_board[4] | green_board[4], 0);

    // lock blocks a legal request
    lock = 1'b1;
    drop_ignored(7'b0000100);
    lock = 1'b0;

    // Fill the rest of the board
    check("t4_not_full", board_full, 0);
    for (int c = 0; c < COLS; c++)
      while (m_h[c] < ROWS) drop_ok(c, 1'b0, '0);
    check("t4_full", board_full, 1);
    check("t4_disjoint", red_board & green_board, 0);
    drop_bad(7'b1000000);
    lock = 1'b1;
    drop_ignored(7'b1000000);
    lock = 1'b0;

    // Reset in the middle of a fall
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_clear();
    @(posedge clk); #1;
    check_all_zero("rst_idle");
    pulse(7'b0000100);
    repeat (8) @(posedge clk);
    #1;
    check("t5_row3", falling_row, 3);
    check("t5_busy", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("post_rst");
    drop_ok(2, 1'b0, '0);
    check("t5_red", red_board, 64'h4);
    check("t5_turn", turn, 1);

    repeat (3) @(posedge clk);
    #1;
    check("exp_q_drained", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/disc_drop_grid.md
Name: disc_drop_grid

Overview:
- Game-grid stage directly downstream of the column-selection/enter stage.
- Consumes one-cycle one-hot column_select pulses and checks each request against column heights.
- Animates the disc falling one row per FALL_TICKS cycles, then commits it to the board for the current player and toggles the turn.
- Provides the board bitmaps, the falling-disc position, and status to the display and win-check logic.

Parameters:
- ROWS, 6, grid rows; row 0 = bottom, ROWS-1 = top.
- COLS, 7, grid columns; must equal the column_select width.
- FALL_TICKS, 4, clock cycles the falling disc spends in each row (>=1); the board build overrides this with a visible rate.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset (0 = reset asserted).
- column_select  in  COLS  one-hot drop request, one-cycle pulse; all-zero = no request.
- lock  in  1  1 = game over; requests ignored silently.
- red_board  out  ROWS*COLS  player-1 discs; bit r*COLS+c.
- green_board  out  ROWS*COLS  player-2 discs; same indexing.
- turn  out  1  0 = player 1 (red) to move, 1 = player 2 (green).
- busy  out  1  1 whenever state != IDLE.
- falling_valid  out  1  1 during FALL.
- falling_row  out  $clog2(ROWS)  current row of the falling disc.
- falling_col  out  $clog2(COLS)  column index of the falling disc.
- drop_done  out  1  one-cycle pulse in LAND.
- invalid  out  1  one-cycle pulse when a request is rejected.
- board_full  out  1  1 when ROWS*COLS discs have been placed.

Behaviour:
- Reset (async, any state):
  - state = IDLE; both boards = 0; all column heights = 0; disc count = 0; turn = 0.
  - falling_valid, falling_row, falling_col = 0; drop_done, invalid, busy, board_full = 0.
  - A disc in flight is discarded.
- States: IDLE, FALL, LAND.
- IDLE, request evaluation at each edge with column_select != 0:
  - If lock = 1: ignore, no pulse.
  - Else if column_select is not one-hot, or board_full = 1, or height[col] == ROWS: invalid = 1 for the next cycle; stay in IDLE.
  - Else accept:
    - Latch col index and target = height[col].
    - Set falling_row = ROWS-1 and clear the tick counter.
    - Enter FALL next cycle.
- Requests arriving in FALL or LAND are ignored silently, with no invalid pulse and no queueing.
- FALL:
  - Tick counter runs 0..FALL_TICKS-1.
  - At terminal count: if falling_row == target, go to LAND; else decrement falling_row and restart the counter.
  - FALL lasts exactly (ROWS - target) * FALL_TICKS cycles.
- LAND (one cycle):
  - drop_done = 1.
  - On the exiting edge: set board bit target*COLS+col in red_board if turn == 0, else green_board; increment height[col] and disc count; toggle turn; return to IDLE.
  - The new disc and the new turn are visible on the first IDLE cycle.
- Latency: accept edge to first IDLE cycle = (ROWS - target) * FALL_TICKS + 1 cycles.
- board_full is registered and asserts on the cycle the count reaches ROWS*COLS.
- lock rising during FALL does not abort the drop; it blocks only new requests.
- Heights saturate at ROWS; red_board & green_board must always be 0.

Decomposition:
- Package connect4_pkg:
  - ROWS, COLS constants.
  - typedef enum {IDLE, FALL, LAND} drop_state_t.
  - typedef enum logic {PLAYER_RED = 0, PLAYER_GREEN = 1} player_t.
  - Function onehot_to_index returning an index plus a valid flag.
- One sub-module, drop_fall_timer:
  - Parameter FALL_TICKS; inputs clk, reset, clear, enable; output tick (terminal-count pulse).
  - Used for the per-row timing.

Test Plan:
- Reset, then column_select = 7'b0001000 pulse (col 3), FALL_TICKS = 4 -> busy for 24 FALL cycles with falling_row stepping 5→0 every 4 cycles; drop_done pulses one cycle; then red_board bit 3 = 1, turn = 1.
- Six accepted drops into col 0, alternating players -> bits 0,7,14,21,28,35 alternate red/green; seventh col-0 request -> invalid pulses, boards and turn unchanged.
- column_select = 7'b0000011, and separately a pulse during FALL -> first gives invalid = 1 with no state change; second is ignored with no invalid and the in-flight drop completes normally.
- Fill all 42 cells -> board_full = 1 after the 42nd drop; any subsequent request -> invalid, no board change; lock = 1 with a valid request -> no pulse, no change.
- Assert reset = 0 mid-FALL (falling_row = 3) -> all outputs 0 immediately and asynchronously; after release, IDLE with empty boards and turn = 0.
